// File: rtl/morse_keyer_if.sv
// morse_keyer_if: character valid/ready handshake between message source and keyer
interface morse_keyer_if;
  logic       charValid;
  logic       charReady;
  logic [5:0] charCode;
  modport master(output charValid, output charCode, input charReady);
  modport slave(input charValid, input charCode, output charReady);
endinterface

// File: rtl/morse_keyer.sv
// morse_keyer: turns character codes into Morse on/off keying at a fixed unit rate
module morse_keyer #(
  parameter int unitCycles  = 4_800_000,
  parameter int counterBits = 24
) (
  input  logic          clkSlow,
  input  logic          reset,
  morse_keyer_if.slave  ch,
  output logic          key,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, LOAD, MARK, GAP} state_t;
  localparam logic [counterBits-1:0] T1  = counterBits'(unitCycles - 1);
  localparam logic [counterBits-1:0] T3  = counterBits'(3 * unitCycles - 1);
  localparam logic [counterBits-1:0] T4  = counterBits'(4 * unitCycles - 1);
  localparam logic [counterBits-1:0] ONE = counterBits'(1);
  state_t                 state, state_nx;
  logic [counterBits-1:0] timer;
  logic [5:0]             code;
  logic [4:0]             pat;
  logic [2:0]             cnt;
  logic [7:0]             ent;
  logic                   accept, done, key_d, busy_d, ready_d;
  // {element count, pattern left-aligned, 1 = dash}
  function automatic logic [7:0] lookup(input logic [5:0] c);
    logic [7:0] e;
    case (c)
      6'd0:  e = {3'd2, 5'b01000};  6'd1:  e = {3'd4, 5'b10000};
      6'd2:  e = {3'd4, 5'b10100};  6'd3:  e = {3'd3, 5'b10000};
      6'd4:  e = {3'd1, 5'b00000};  6'd5:  e = {3'd4, 5'b00100};
      6'd6:  e = {3'd3, 5'b11000};  6'd7:  e = {3'd4, 5'b00000};
      6'd8:  e = {3'd2, 5'b00000};  6'd9:  e = {3'd4, 5'b01110};
      6'd10: e = {3'd3, 5'b10100};  6'd11: e = {3'd4, 5'b01000};
      6'd12: e = {3'd2, 5'b11000};  6'd13: e = {3'd2, 5'b10000};
      6'd14: e = {3'd3, 5'b11100};  6'd15: e = {3'd4, 5'b01100};
      6'd16: e = {3'd4, 5'b11010};  6'd17: e = {3'd3, 5'b01000};
      6'd18: e = {3'd3, 5'b00000};  6'd19: e = {3'd1, 5'b10000};
      6'd20: e = {3'd3, 5'b00100};  6'd21: e = {3'd4, 5'b00010};
      6'd22: e = {3'd3, 5'b01100};  6'd23: e = {3'd4, 5'b10010};
      6'd24: e = {3'd4, 5'b10110};  6'd25: e = {3'd4, 5'b11000};
      6'd26: e = {3'd5, 5'b11111};  6'd27: e = {3'd5, 5'b01111};
      6'd28: e = {3'd5, 5'b00111};  6'd29: e = {3'd5, 5'b00011};
      6'd30: e = {3'd5, 5'b00001};  6'd31: e = {3'd5, 5'b00000};
      6'd32: e = {3'd5, 5'b10000};  6'd33: e = {3'd5, 5'b11000};
      6'd34: e = {3'd5, 5'b11100};  6'd35: e = {3'd5, 5'b11110};
      default: e = 8'd0;
    endcase
    return e;
  endfunction
  assign ent    = lookup(code);
  assign accept = ch.charValid && ch.charReady;
  assign done   = timer == '0;
  always_ff @(posedge clkSlow or posedge reset)
    if (reset) begin
      state        <= IDLE;
      key          <= 1'b0;
      busy         <= 1'b0;
      ch.charReady <= 1'b0;
    end else begin
      state        <= state_nx;
      key          <= key_d;
      busy         <= busy_d;
      ch.charReady <= ready_d;
    end
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? LOAD : IDLE;
      LOAD:    state_nx = code > 6'd36 ? IDLE : code == 6'd36 ? GAP : MARK;
      MARK:    state_nx = done ? GAP : MARK;
      GAP:     state_nx = !done ? GAP : cnt != 3'd0 ? MARK : accept ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // ready opens in the last cycle of a final gap so a held charValid lands straight in LOAD
  always_comb begin
    key_d   = state_nx == MARK;
    busy_d  = state_nx != IDLE;
    ready_d = !accept && (state == IDLE || (state == GAP && cnt == 3'd0 && timer <= ONE));
  end
  always_ff @(posedge clkSlow or posedge reset)
    if (reset) begin
      timer <= '0;
      pat   <= '0;
      cnt   <= '0;
      code  <= '0;
    end else begin
      if (accept) code <= ch.charCode;
      case (state)
        LOAD: begin
          pat   <= ent[4:0];
          cnt   <= ent[7:5];
          timer <= code == 6'd36 ? T4 : ent[4] ? T3 : T1;
        end
        MARK:
          if (done) begin
            pat   <= {pat[3:0], 1'b0};
            cnt   <= cnt - 3'd1;
            timer <= cnt == 3'd1 ? T3 : T1;
          end else timer <= timer - ONE;
        GAP:     timer <= done ? (pat[4] ? T3 : T1) : timer - ONE;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: directed checks of keying patterns, handshake timing and reset
module tb_morse_keyer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key, busy;
  int   total = 0, bad = 0;
  logic kq[$], bq[$], yq[$];
  int   rq[$], eq[$];
  morse_keyer_if ki();
  morse_keyer #(.unitCycles(4), .counterBits(8)) dut (
    .clkSlow(clk), .reset(rst), .ch(ki.slave), .key(key), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send(input string tag, input logic [5:0] c);
    @(negedge clk);
    ki.charValid = 1'b1;
    ki.charCode  = c;
    chk({tag, ".ready_before"}, 32'(ki.charReady), 1);
    @(negedge clk);
    ki.charValid = 1'b0;
  endtask
  task automatic rec(input int n);
    kq.delete(); bq.delete(); yq.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      kq.push_back(key);
      bq.push_back(busy);
      yq.push_back(ki.charReady);
    end
  endtask
  task automatic chk_runs(input string tag);
    int n;
    rq.delete();
    n = 1;
    for (int i = 1; i < kq.size(); i++)
      if (kq[i] === kq[i-1]) n++;
      else begin
        rq.push_back(n);
        n = 1;
      end
    rq.push_back(n);
    chk({tag, ".key0"}, 32'(kq[0]), 0);
    chk({tag, ".nruns"}, rq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < rq.size(); i++)
      chk($sformatf("%s.run%0d", tag, i), rq[i], eq[i]);
  endtask
  initial begin
    ki.charValid = 1'b0;
    ki.charCode  = 6'd0;
    repeat (2) @(negedge clk);
    chk("rst.key", 32'(key), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ready", 32'(ki.charReady), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_up", 32'(ki.charReady), 1);
    send("E", 6'd4);
    rec(20);
    eq = '{1, 4, 15};
    chk_runs("E");
    chk("E.busy_acc", 32'(bq[0]), 1);
    chk("E.ready_acc", 32'(yq[0]), 0);
    chk("E.ready_15", 32'(yq[15]), 0);
    chk("E.ready_16", 32'(yq[16]), 1);
    chk("E.busy_16", 32'(bq[16]), 1);
    chk("E.busy_17", 32'(bq[17]), 0);
    send("A", 6'd0);
    rec(36);
    eq = '{1, 4, 4, 12, 15};
    chk_runs("A");
    chk("A.busy_32", 32'(bq[32]), 1);
    chk("A.busy_33", 32'(bq[33]), 0);
    @(negedge clk);
    ki.charValid = 1'b1;
    ki.charCode  = 6'd4;
    kq.delete(); bq.delete(); yq.delete();
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (i == 1) ki.charCode = 6'd36;
      if (i == 18) ki.charCode = 6'd4;
      if (i == 35) ki.charValid = 1'b0;
      kq.push_back(key);
      bq.push_back(busy);
      yq.push_back(ki.charReady);
    end
    eq = '{1, 4, 30, 4, 16};
    chk_runs("ESE");
    chk("ESE.ready_20", 32'(yq[20]), 0);
    chk("ESE.busy_17", 32'(bq[17]), 1);
    chk("ESE.ready_33", 32'(yq[33]), 1);
    chk("ESE.ready_34", 32'(yq[34]), 0);
    send("zero", 6'd26);
    rec(92);
    eq = '{1, 12, 4, 12, 4, 12, 4, 12, 4, 12, 15};
    chk_runs("zero");
    chk("zero.busy_88", 32'(bq[88]), 1);
    chk("zero.busy_89", 32'(bq[89]), 0);
    send("inv", 6'd50);
    rec(6);
    eq = '{6};
    chk_runs("inv");
    chk("inv.busy_0", 32'(bq[0]), 1);
    chk("inv.busy_1", 32'(bq[1]), 0);
    chk("inv.ready_1", 32'(yq[1]), 0);
    chk("inv.ready_2", 32'(yq[2]), 1);
    send("T", 6'd19);
    chk("T.key_load", 32'(key), 0);
    @(negedge clk);
    chk("T.key_1", 32'(key), 1);
    @(negedge clk);
    chk("T.key_2", 32'(key), 1);
    rst = 1'b1;
    #1;
    chk("T.rst_key", 32'(key), 0);
    chk("T.rst_busy", 32'(busy), 0);
    chk("T.rst_ready", 32'(ki.charReady), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("T.rel_ready", 32'(ki.charReady), 0);
    @(negedge clk);
    chk("T.rel_ready_up", 32'(ki.charReady), 1);
    chk("T.rel_busy", 32'(busy), 0);
    send("E2", 6'd4);
    rec(20);
    eq = '{1, 4, 15};
    chk_runs("E2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
